// File: rtl/credit_manager.sv
// credit_manager: debounces the raw coin key, converts coins into credits and
// grants or refuses game-start requests by spending one credit. The credit
// count saturates at MAX_CREDITS so it always fits the single display digit.
module credit_manager #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int COINS_PER_CREDIT = 2,
    parameter int MAX_CREDITS      = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coinKey,
    input  logic       startReq,
    output logic [3:0] credits,
    output logic [1:0] coinCount,
    output logic       creditAdded,
    output logic       coinReject,
    output logic       startAck,
    output logic       startDeny
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0]        CREDIT_MAX = 4'(MAX_CREDITS);
    localparam logic [1:0]        COIN_LAST  = 2'(COINS_PER_CREDIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    logic             coin_meta;
    logic             coin_s;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             coin_evt;
    logic             start_q;

    logic             start_edge;
    logic             at_max;
    logic             inc;
    logic             grant;
    logic             deny;
    logic             reject;
    logic [1:0]       coin_count_next;
    logic [3:0]       credits_next;

    // Two-flop synchronizer: the coin key is asynchronous to clk.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values and the two stages really form a chain.
        if (reset) begin
            coin_meta <= 1'b0;
            coin_s    <= 1'b0;
        end else begin
            coin_meta <= coinKey;
            coin_s    <= coin_meta;
        end
    end

    // Debounce state register and stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Debounce next-state: a level must hold for DEBOUNCE_CYCLES samples to count.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch forms.
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (coin_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!coin_s)              state_next = IDLE;
                else if (cnt == CNT_DONE) state_next = PRESSED;
                else                      cnt_next   = cnt + CNT_ONE;
            end
            PRESSED: begin
                if (!coin_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (coin_s)               state_next = PRESSED;
                else if (cnt == CNT_DONE) state_next = IDLE;
                else                      cnt_next   = cnt + CNT_ONE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Debounce output: one coin event on the cycle the press is confirmed.
    always_comb begin
        coin_evt = (state == PRESS_WAIT) && coin_s && (cnt == CNT_DONE);
    end

    // Coin accumulation and start arbitration; inc and dec resolve together.
    always_comb begin
        start_edge      = startReq & ~start_q;
        at_max          = (credits == CREDIT_MAX);
        reject          = coin_evt & at_max;
        inc             = coin_evt & ~at_max & (coinCount == COIN_LAST);
        grant           = start_edge & ((credits != 4'd0) | inc);
        deny            = start_edge & (credits == 4'd0) & ~inc;
        coin_count_next = coinCount;
        if (coin_evt && !at_max) begin
            coin_count_next = inc ? 2'd0 : coinCount + 2'd1;
        end
        unique case ({inc, grant})
            2'b10:   credits_next = credits + 4'd1;
            2'b01:   credits_next = credits - 4'd1;
            default: credits_next = credits;
        endcase
    end

    // Registered credit state, start edge flop and one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q     <= 1'b0;
            credits     <= 4'd0;
            coinCount   <= 2'd0;
            creditAdded <= 1'b0;
            coinReject  <= 1'b0;
            startAck    <= 1'b0;
            startDeny   <= 1'b0;
        end else begin
            start_q     <= startReq;
            credits     <= credits_next;
            coinCount   <= coin_count_next;
            creditAdded <= inc;
            coinReject  <= reject;
            startAck    <= grant;
            startDeny   <= deny;
        end
    end

endmodule
